// File: rtl/lcd_char_ctrl.sv
// HD44780 character front end: power-up wait, 8-bit init sequence, then ASCII -> {rs,data} words.
// Optional end-of-line DDRAM address insertion is enabled by defining LCD_LINE_WRAP_EN.
module lcd_char_ctrl #(
  parameter int POWERUP_CYCLES = 2_000_000,
  parameter int LINE_LEN       = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  output logic       init_done_o,
  output logic [8:0] data_o,
  output logic       data_valid_o,
  input  logic       device_ready_i
);

  localparam int PW = $clog2(POWERUP_CYCLES + 1);
  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [PW-1:0] PU_LAST  = PW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SEND_CHAR, SEND_ADDR} state_t;

  function automatic logic [8:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 9'h038;
      2'd1:    init_rom = 9'h00C;
      2'd2:    init_rom = 9'h001;
      default: init_rom = 9'h006;
    endcase
  endfunction

  state_t        state_q;
  logic [PW-1:0] pu_cnt_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] col_q;
  logic [8:0]    data_q;
  logic          vld_q;
  logic          done_q;
`ifdef LCD_LINE_WRAP_EN
  logic          line_q;
`endif

  logic xfer;
  assign xfer = vld_q & device_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= PWRUP;
      pu_cnt_q <= '0;
      idx_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
      line_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        PWRUP: begin
          if (pu_cnt_q == PU_LAST) begin
            data_q  <= init_rom(2'd0);
            vld_q   <= 1'b1;
            idx_q   <= 2'd0;
            state_q <= INIT;
          end else begin
            pu_cnt_q <= pu_cnt_q + PW'(1);
          end
        end
        INIT: begin
          if (xfer) begin
            if (idx_q == 2'd3) begin
              vld_q   <= 1'b0;
              done_q  <= 1'b1;
              col_q   <= '0;
`ifdef LCD_LINE_WRAP_EN
              line_q  <= 1'b0;
`endif
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_q + 2'd1;
              data_q <= init_rom(idx_q + 2'd1);
            end
          end
        end
        IDLE: begin
          if (char_valid_i) begin
            data_q  <= {1'b1, char_i};
            vld_q   <= 1'b1;
            state_q <= SEND_CHAR;
          end
        end
        SEND_CHAR: begin
          if (xfer) begin
`ifdef LCD_LINE_WRAP_EN
            if (col_q == COL_LAST) begin
              // Next line start: 0x40 offset for line 1, 0x00 for line 0.
              col_q   <= '0;
              line_q  <= ~line_q;
              data_q  <= line_q ? 9'h080 : 9'h0C0;
              state_q <= SEND_ADDR;
            end else begin
              col_q   <= col_q + CW'(1);
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
`else
            if (col_q != COL_LAST) col_q <= col_q + CW'(1);
            vld_q   <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        SEND_ADDR: begin
          if (xfer) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= PWRUP;
      endcase
    end
  end

  assign char_ready_o = (state_q == IDLE);
  assign init_done_o  = done_q;
  assign data_o       = data_q;
  assign data_valid_o = vld_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Scoreboard bench for lcd_char_ctrl: expected words queued at stimulus, popped on each downstream transfer.
module tb_lcd_char_ctrl;
  localparam int PU = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       init_done;
  logic [8:0] data;
  logic       data_valid;
  logic       dev_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic       prev_vld = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [8:0] prev_dat = '0;

  lcd_char_ctrl #(.POWERUP_CYCLES(PU), .LINE_LEN(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .char_i(char_in), .char_valid_i(char_valid),
    .char_ready_o(char_ready), .init_done_o(init_done), .data_o(data),
    .data_valid_o(data_valid), .device_ready_i(dev_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: transfers pop the scoreboard; pending words must hold stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld  = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (prev_vld && !prev_xfer) begin
        chk("hold_valid", {31'b0, data_valid}, 32'd1);
        chk("hold_data", {23'b0, data}, {23'b0, prev_dat});
      end
      if (data_valid && dev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", data, $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("xfer_word", {23'b0, data}, {23'b0, e});
        end
      end
      prev_vld  = data_valid;
      prev_dat  = data;
      prev_xfer = data_valid && dev_ready;
    end
  end

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  // Called at posedge+1 right after reset release.
  task automatic powerup_check();
    repeat (PU - 1) @(posedge clk);
    #1 chk("pwrup_still_idle", {31'b0, data_valid}, 32'd0);
    @(posedge clk);
    #1 chk("pwrup_valid_rise", {31'b0, data_valid}, 32'd1);
    chk("pwrup_first_word", {23'b0, data}, 32'h038);
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    char_in = c;
    char_valid = 1'b1;
    exp_q.push_back({1'b1, c});
    @(negedge clk);
    while (!char_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("char_accept", {31'b0, char_ready}, 32'd1);
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state, with a character held through PWRUP/INIT to prove it is ignored.
    char_in = 8'h5A;
    char_valid = 1'b1;
    #2;
    chk("rst_data", {23'b0, data}, 32'h000);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_ready", {31'b0, char_ready}, 32'd0);
    chk("rst_done", {31'b0, init_done}, 32'd0);
    push_init();
    exp_q.push_back(9'h15A);
    @(posedge clk);
    #1 rst_n = 1'b1;
    powerup_check();
    repeat (3) @(posedge clk);
    #1 chk("init_not_done", {31'b0, init_done}, 32'd0);
    chk("ready_during_init", {31'b0, char_ready}, 32'd0);
    @(posedge clk);
    #1 chk("init_done", {31'b0, init_done}, 32'd1);
    chk("ready_after_init", {31'b0, char_ready}, 32'd1);
    @(posedge clk);
    #1 chk("held_char_word", {23'b0, data}, 32'h15A);
    chk("held_char_valid", {31'b0, data_valid}, 32'd1);
    chk("busy_ready", {31'b0, char_ready}, 32'd0);
    char_valid = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_xfer", {31'b0, char_ready}, 32'd1);
    chk("valid_after_xfer", {31'b0, data_valid}, 32'd0);

    // Single character under backpressure.
    dev_ready = 1'b0;
    char_in = 8'h41;
    char_valid = 1'b1;
    exp_q.push_back(9'h141);
    @(posedge clk);
    #1 char_valid = 1'b0;
    chk("bp_ready_low", {31'b0, char_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", {23'b0, data}, 32'h141);
      chk("bp_hold_valid", {31'b0, data_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    dev_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_ready_back", {31'b0, char_ready}, 32'd1);
    chk("bp_valid_drop", {31'b0, data_valid}, 32'd0);

    // Reset while 0x001 is pending.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_init();
    dev_ready = 1'b0;
    powerup_check();
    dev_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 dev_ready = 1'b0;
    chk("pending_clear", {23'b0, data}, 32'h001);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", {31'b0, data_valid}, 32'd0);
    chk("mid_rst_data", {23'b0, data}, 32'h000);
    chk("mid_rst_done", {31'b0, init_done}, 32'd0);
    chk("mid_rst_ready", {31'b0, char_ready}, 32'd0);
    chk("mid_rst_left", exp_q.size(), 32'd2);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dev_ready = 1'b1;
    push_init();
    powerup_check();
    repeat (4) @(posedge clk);
    #1 chk("reinit_done", {31'b0, init_done}, 32'd1);

    // Character stream from column 0.
`ifdef LCD_LINE_WRAP_EN
    for (int i = 0; i < 32; i++) begin
      send_char(8'h40 + 8'(i));
      if (i == 15) exp_q.push_back(9'h0C0);
      if (i == 31) exp_q.push_back(9'h080);
    end
`else
    for (int i = 0; i < 20; i++) send_char(8'h60 + 8'(i));
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_valid", {31'b0, data_valid}, 32'd0);
    chk("final_ready", {31'b0, char_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
